// File: rtl/adder_nibble_seq.sv
// Nibble-serial operand feed / result collect around an external 4-bit adder.
// Ports: in_* valid/ready operand side, add_* adder side, out_* result side.
// Optional: define ADDER_SEQ_SUB_EN to add in_sub (A - B via inverted B).
module adder_nibble_seq #(
  parameter int WORDS = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [4*WORDS-1:0] in_a,
  input  logic [4*WORDS-1:0] in_b,
  input  logic               in_cin,
`ifdef ADDER_SEQ_SUB_EN
  input  logic               in_sub,
`endif
  output logic [3:0]         add_a,
  output logic [3:0]         add_b,
  output logic               add_cin,
  input  logic [3:0]         add_s,
  input  logic               add_cout,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [4*WORDS-1:0] out_sum,
  output logic               out_cout
);

  localparam int N  = 4 * WORDS;
  localparam int IW = (WORDS > 1) ? $clog2(WORDS) : 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DONE
  } state_e;

  state_e        state_q, state_d;
  logic [IW-1:0] idx_q, idx_d;
  logic [N-1:0]  a_q, a_d;
  logic [N-1:0]  b_q, b_d;
  logic [N-1:0]  sum_q, sum_d;
  logic          cin_q, cin_d;
  logic          sub_q, sub_d;
  logic          carry_q, carry_d;
  logic          cout_q, cout_d;
  logic          sub_in;
  logic          last;
  logic [3:0]    a_nib;
  logic [3:0]    b_nib;

`ifdef ADDER_SEQ_SUB_EN
  assign sub_in = in_sub;
`else
  assign sub_in = 1'b0;
`endif

  assign last  = (idx_q == IW'(WORDS - 1));
  assign a_nib = a_q[{idx_q, 2'b00} +: 4];
  assign b_nib = b_q[{idx_q, 2'b00} +: 4];

  // Adder drive kept apart from next-state logic so the external
  // combinational adder loop does not pass through one process.
  always_comb begin
    add_a   = 4'h0;
    add_b   = 4'h0;
    add_cin = 1'b0;
    if (state_q == S_RUN) begin
      add_a = a_nib;
      // Subtract: invert B and flip the initial carry (two's complement).
      add_b = sub_q ? ~b_nib : b_nib;
      add_cin = (idx_q == '0) ? (cin_q ^ sub_q) : carry_q;
    end
  end

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    a_d       = a_q;
    b_d       = b_q;
    sum_d     = sum_q;
    cin_d     = cin_q;
    sub_d     = sub_q;
    carry_d   = carry_q;
    cout_d    = cout_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          a_d     = in_a;
          b_d     = in_b;
          cin_d   = in_cin;
          sub_d   = sub_in;
          idx_d   = '0;
          state_d = S_RUN;
        end
      end
      S_RUN: begin
        sum_d[{idx_q, 2'b00} +: 4] = add_s;
        carry_d = add_cout;
        idx_d   = idx_q + 1'b1;
        if (last) begin
          cout_d  = add_cout;
          idx_d   = '0;
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      idx_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
      cin_q   <= 1'b0;
      sub_q   <= 1'b0;
      carry_q <= 1'b0;
      cout_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sum_q   <= sum_d;
      cin_q   <= cin_d;
      sub_q   <= sub_d;
      carry_q <= carry_d;
      cout_q  <= cout_d;
    end
  end

  assign out_sum  = sum_q;
  assign out_cout = cout_q;

endmodule

// File: tb/tb_adder_nibble_seq.sv
// Scoreboard bench for adder_nibble_seq with a behavioural 4-bit adder.
// Expected {cout,sum} is computed with plain wide arithmetic.
module tb_adder_nibble_seq;

  localparam int W = 4;
  localparam int N = 4 * W;
`ifdef ADDER_SEQ_SUB_EN
  localparam bit HAS_SUB = 1'b1;
`else
  localparam bit HAS_SUB = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [N-1:0] in_a;
  logic [N-1:0] in_b;
  logic         in_cin;
  logic         in_sub;
  logic [3:0]   add_a;
  logic [3:0]   add_b;
  logic         add_cin;
  logic [3:0]   add_s;
  logic         add_cout;
  logic         out_valid;
  logic         out_ready;
  logic [N-1:0] out_sum;
  logic         out_cout;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;
  bit rand_rdy = 1'b0;

  logic [N:0] exp_q[$];
  int         acc_q[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  assign {add_cout, add_s} = {1'b0, add_a} + {1'b0, add_b} + {4'b0, add_cin};

  adder_nibble_seq #(.WORDS(W)) dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_a     (in_a),
    .in_b     (in_b),
    .in_cin   (in_cin),
`ifdef ADDER_SEQ_SUB_EN
    .in_sub   (in_sub),
`endif
    .add_a    (add_a),
    .add_b    (add_b),
    .add_cin  (add_cin),
    .add_s    (add_s),
    .add_cout (add_cout),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_sum  (out_sum),
    .out_cout (out_cout)
  );

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (cyc %0d)", nm, act, exp, cyc);
    end
  endtask

  function automatic logic [N:0] model(logic [N-1:0] a, logic [N-1:0] b,
                                      logic c, logic s);
    logic [N:0] r;
    if (HAS_SUB && s)
      r = {1'b0, a} + {1'b0, ~b} + {{N{1'b0}}, ~c};
    else
      r = {1'b0, a} + {1'b0, b} + {{N{1'b0}}, c};
    return r;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Returns at posedge+1 just after the accept edge.
  task automatic send(logic [N-1:0] a, logic [N-1:0] b, logic c, logic s);
    bit acc;
    int n;
    acc = 1'b0;
    n = 0;
    in_a = a;
    in_b = b;
    in_cin = c;
    in_sub = s;
    in_valid = 1'b1;
    while (!acc && n < 100) begin
      @(negedge clk);
      if (in_ready) acc = 1'b1;
      else n++;
    end
    if (!acc) begin
      chk("accept_timeout", 32'd0, 32'd1);
    end else begin
      exp_q.push_back(model(a, b, c, s));
      acc_q.push_back(cyc + 1);
    end
    tick();
    in_valid = 1'b0;
    in_a = N'($urandom);
    in_b = N'($urandom);
    in_cin = 1'($urandom);
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    while ((exp_q.size() != 0 || !in_ready) && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (n >= 200) chk("drain_timeout", 32'd0, 32'd1);
    tick();
  endtask

  // Monitor: checks result against scoreboard head while valid,
  // pops on handshake, and checks accept-to-valid latency.
  initial begin
    logic pv;
    pv = 1'b0;
    forever begin
      @(negedge clk);
      if (rst) begin
        pv = 1'b0;
      end else begin
        if (out_valid) begin
          if (!pv) begin
            if (acc_q.size() != 0)
              chk("latency", 32'(cyc - acc_q.pop_front()), 32'(W));
            else
              chk("valid_without_accept", 32'd1, 32'd0);
          end
          if (exp_q.size() == 0) begin
            chk("unexpected_result", 32'd1, 32'd0);
          end else begin
            chk("result", 32'({out_cout, out_sum}), 32'(exp_q[0]));
            chk("in_ready_busy", 32'(in_ready), 32'd0);
            if (out_ready) void'(exp_q.pop_front());
          end
        end
        pv = out_valid;
      end
    end
  end

  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (rand_rdy) out_ready = 1'($urandom);
    end
  end

  initial begin
    int n;
    rst = 1'b1;
    in_valid = 1'b0;
    in_a = '0;
    in_b = '0;
    in_cin = 1'b0;
    in_sub = 1'b0;
    out_ready = 1'b1;
    tick();
    tick();
    rst = 1'b0;

    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_sum", 32'(out_sum), 32'd0);
    chk("rst_out_cout", 32'(out_cout), 32'd0);
    chk("idle_add", 32'({add_a, add_b, add_cin}), 32'd0);

    send(16'h1234, 16'h1111, 1'b0, 1'b0);
    wait_drain();
    chk("basic_sum", 32'(out_sum), 32'h2345);
    chk("basic_cout", 32'(out_cout), 32'd0);

    send(16'hFFFF, 16'h0001, 1'b0, 1'b0);
    wait_drain();
    chk("ripple_sum", 32'(out_sum), 32'h0000);
    chk("ripple_cout", 32'(out_cout), 32'd1);

    send(16'hFFFF, 16'hFFFF, 1'b1, 1'b0);
    for (int i = 0; i < W; i++) begin
      chk("cin_seq", 32'(add_cin), 32'd1);
      chk("run_nibbles", 32'({add_a, add_b}), 32'hFF);
      chk("run_in_ready", 32'(in_ready), 32'd0);
      tick();
    end
    chk("done_add", 32'({add_a, add_b, add_cin}), 32'd0);
    wait_drain();

    // Back-pressure with junk offered upstream while DONE.
    out_ready = 1'b0;
    send(16'hA5A5, 16'h1357, 1'b1, 1'b0);
    n = 0;
    while (!out_valid && n < 50) begin
      tick();
      n++;
    end
    chk("bp_valid_seen", 32'(out_valid), 32'd1);
    for (int i = 0; i < 5; i++) begin
      in_valid = 1'b1;
      in_a = N'($urandom);
      in_b = N'($urandom);
      chk("bp_in_ready", 32'(in_ready), 32'd0);
      chk("bp_out_valid", 32'(out_valid), 32'd1);
      tick();
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    tick();
    chk("bp_release_ready", 32'(in_ready), 32'd1);
    chk("bp_release_valid", 32'(out_valid), 32'd0);

    // Reset during RUN at idx 2.
    send(16'h1234, 16'h1111, 1'b0, 1'b0);
    tick();
    tick();
    rst = 1'b1;
    exp_q.delete();
    acc_q.delete();
    tick();
    rst = 1'b0;
    chk("abort_in_ready", 32'(in_ready), 32'd1);
    chk("abort_out_valid", 32'(out_valid), 32'd0);
    chk("abort_out_sum", 32'(out_sum), 32'd0);
    chk("abort_out_cout", 32'(out_cout), 32'd0);
    send(16'h0F0F, 16'h0101, 1'b1, 1'b0);
    wait_drain();
    chk("post_abort_sum", 32'(out_sum), 32'h1011);

    if (HAS_SUB) begin
      send(16'h0005, 16'h0007, 1'b0, 1'b1);
      wait_drain();
      chk("sub_sum", 32'(out_sum), 32'hFFFE);
      chk("sub_cout", 32'(out_cout), 32'd0);
    end

    // Randomized traffic with random downstream stalls.
    rand_rdy = 1'b1;
    for (int i = 0; i < 60; i++) begin
      n = int'($urandom_range(0, 3));
      for (int j = 0; j < n; j++) tick();
      send(N'($urandom), N'($urandom), 1'($urandom), 1'($urandom));
    end
    rand_rdy = 1'b0;
    out_ready = 1'b1;
    wait_drain();
    chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/adder_nibble_seq.md
Name: adder_nibble_seq

Overview:
- Sequential operand-feed and result-collect stage wrapped around the existing 4-bit structural ripple adder.
- Accepts a WORDS*4-bit operand pair over a valid/ready handshake.
- Drives one nibble per clock into the external 4-bit adder, chaining carry through a register.
- Assembles the wide sum and carry-out, then presents them downstream over valid/ready.

Parameters:
- WORDS, 4, number of 4-bit nibbles per operand; operand/sum width is 4*WORDS; legal range 1..16.

Ports:
- clk  input  1  single clock; all state updates on rising edge.
- rst  input  1  reset, synchronous and active-high.
- in_valid  input  1  operand pair and cin are valid.
- in_ready  output  1  block can accept operands.
- in_a  input  4*WORDS  operand A.
- in_b  input  4*WORDS  operand B.
- in_cin  input  1  carry-in for nibble 0.
- add_a  output  4  nibble of A to adder.
- add_b  output  4  nibble of B to adder.
- add_cin  output  1  carry-in to adder.
- add_s  input  4  adder sum nibble.
- add_cout  input  1  adder carry-out.
- out_valid  output  1  result valid.
- out_ready  input  1  downstream accepts result.
- out_sum  output  4*WORDS  assembled sum.
- out_cout  output  1  final carry-out.

Behaviour:
- Reset is synchronous and active-high: one clock with rst=1 forces state IDLE, idx=0, carry reg=0, sum reg=0, operand regs=0, out_valid=0, out_cout=0, out_sum=0. in_ready=1 after reset. Reset mid-RUN or mid-DONE aborts; the partial result is discarded and never presented.
- State IDLE: in_ready=1. On in_valid&&in_ready, latch in_a, in_b, in_cin; idx<=0; go to RUN.
- State RUN: in_ready=0. Adder outputs are combinational from registers:
  - add_a=A[4*idx+:4], add_b=B[4*idx+:4].
  - add_cin = latched cin when idx==0, otherwise carry reg.
  - Each edge: sum[4*idx+:4]<=add_s, carry reg<=add_cout, idx<=idx+1.
  - When idx==WORDS-1, also out_cout<=add_cout and go to DONE.
- State DONE: out_valid=1, in_ready=0. out_sum and out_cout hold stable until out_valid&&out_ready; on that edge go to IDLE (out_valid=0).
- No acceptance in DONE, even if out_ready=1 in the same cycle; the next operand is accepted in IDLE one cycle later. Throughput is one operation per WORDS+2 cycles.
- Latency: out_valid rises exactly WORDS edges after the accept edge.
- In IDLE and DONE: add_a=0, add_b=0, add_cin=0.
- Arithmetic: {out_cout,out_sum} = in_a + in_b + in_cin, modulo 2^(4*WORDS+1). Wrap-around is expressed only via out_cout.
- WORDS=1 edge case: RUN lasts one cycle; nibble 0 uses in_cin and is also the last nibble.
- in_a/in_b changes while not accepted are ignored. in_valid may drop without acceptance; there is no requirement on the upstream to hold it.

Optional Feature:
- Macro ADDER_SEQ_SUB_EN.
- When defined: add input port in_sub (1 bit), latched with the operands.
  - If the latched sub=1, add_b carries the bitwise-inverted nibble of B, and nibble-0 add_cin = ~in_cin.
  - With in_cin=0 this yields A-B in two's complement; out_cout=1 means no borrow.
- When undefined: port in_sub is absent and behaviour is pure addition as above.

Test Plan:
- Reset then WORDS=4, in_a=0x1234, in_b=0x1111, in_cin=0, out_ready=1 -> out_valid exactly 4 edges after accept; out_sum=0x2345, out_cout=0.
- in_a=0xFFFF, in_b=0x0001, in_cin=0 -> carry ripples through all nibbles; out_sum=0x0000, out_cout=1.
- in_a=0xFFFF, in_b=0xFFFF, in_cin=1 -> out_sum=0xFFFF, out_cout=1. Per-cycle add_cin sequence is 1,1,1,1.
- Back-pressure: out_ready=0 for 5 cycles in DONE -> out_valid and out_sum stable, in_ready=0 and new in_valid ignored. out_ready=1 -> IDLE next cycle, in_ready=1.
- Assert rst during RUN at idx=2 -> next cycle IDLE, out_valid=0, out_sum=0, in_ready=1. A fresh operation completes correctly.
- ADDER_SEQ_SUB_EN defined, in_sub=1, in_a=0x0005, in_b=0x0007, in_cin=0 -> out_sum=0xFFFE, out_cout=0.
